// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the controller and alu_seq.
//   start/ctrl/ain/bin : request from controller (master -> slave)
//   busy/done          : status back to controller
//   sout/cflag/zflag   : registered result and flags
//   vflag              : signed-overflow flag, only with ALU_VFLAG_EN
//
// Handshake: start acts as "valid" and is accepted on a rising edge only
// while the ALU is idle (busy=0); there is no separate ready, busy=1 means
// "not ready" and any start seen then is dropped. Each accepted request
// yields exactly one done pulse; sout/flags are valid from that cycle on
// and hold until the next completion.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sout;
  logic             cflag;
  logic             zflag;
`ifdef ALU_VFLAG_EN
  logic             vflag;
`endif

  modport master (
    output start, ctrl, ain, bin,
    input  busy, done, sout, cflag, zflag
`ifdef ALU_VFLAG_EN
    , input vflag
`endif
  );

  modport slave (
    input  start, ctrl, ain, bin,
    output busy, done, sout, cflag, zflag
`ifdef ALU_VFLAG_EN
    , output vflag
`endif
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered flags and iterative multiply.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : alu_seq_if slave (start/ctrl/ain/bin in; busy/done/sout/flags out)
//   dbg_state : current FSM state (0 = IDLE, 1 = BUSY)
// Optional macro ALU_VFLAG_EN adds the vflag signed-overflow register.
// Single-cycle ops complete on the edge that accepts start; MUL walks a
// WIDTH-iteration shift-add loop in the BUSY state.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  alu_seq_if.slave     bus,
  output logic         dbg_state
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_INC = 3'b000;
  localparam logic [2:0] OP_DEC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_ADC = 3'b100;
  localparam logic [2:0] OP_SBB = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sout_q, sout_d;
  logic               cflag_q, cflag_d;
  logic               zflag_q, zflag_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   b_op;
  logic               cin;
  logic               is_sub;
  logic [WIDTH:0]     r;
  logic [2*WIDTH-1:0] acc_add;
`ifdef ALU_VFLAG_EN
  logic               vflag_q, vflag_d;
  logic               v_calc;
`endif

  always_comb begin
    // INC/DEC use a constant 1 as the second operand; carry-in only for ADC/SBB.
    b_op   = ((bus.ctrl == OP_INC) || (bus.ctrl == OP_DEC)) ? WIDTH'(1) : bus.bin;
    cin    = ((bus.ctrl == OP_ADC) || (bus.ctrl == OP_SBB)) ? cflag_q : 1'b0;
    is_sub = (bus.ctrl == OP_DEC) || (bus.ctrl == OP_SUB) ||
             (bus.ctrl == OP_SBB) || (bus.ctrl == OP_CMP);
    if (is_sub) r = {1'b0, bus.ain} - {1'b0, b_op} - {{WIDTH{1'b0}}, cin};
    else        r = {1'b0, bus.ain} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
`ifdef ALU_VFLAG_EN
    if (is_sub) v_calc = (bus.ain[WIDTH-1] != b_op[WIDTH-1]) && (r[WIDTH-1] != bus.ain[WIDTH-1]);
    else        v_calc = (bus.ain[WIDTH-1] == b_op[WIDTH-1]) && (r[WIDTH-1] != bus.ain[WIDTH-1]);
`endif
    // One shift-add step: the partial product for bit cnt of the multiplier.
    acc_add = acc_q + (mplier_q[0] ? (mcand_q << cnt_q) : '0);
  end

  always_comb begin
    state_d  = state_q;
    sout_d   = sout_q;
    cflag_d  = cflag_q;
    zflag_d  = zflag_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`ifdef ALU_VFLAG_EN
    vflag_d  = vflag_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.ctrl == OP_MUL) begin
            state_d  = S_BUSY;
            mcand_d  = {{WIDTH{1'b0}}, bus.ain};
            mplier_d = bus.bin;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            // CMP only touches the flags; sout keeps its last result.
            if (bus.ctrl != OP_CMP) sout_d = r[WIDTH-1:0];
            cflag_d = r[WIDTH];
            zflag_d = (r == '0);
`ifdef ALU_VFLAG_EN
            vflag_d = v_calc;
`endif
            done_d  = 1'b1;
          end
        end
      end
      S_BUSY: begin
        acc_d    = acc_add;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          sout_d  = acc_add[WIDTH-1:0];
          cflag_d = |acc_add[2*WIDTH-1:WIDTH];
          zflag_d = (acc_add == '0);
`ifdef ALU_VFLAG_EN
          vflag_d = 1'b0;
`endif
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sout_q   <= '0;
      cflag_q  <= 1'b0;
      zflag_q  <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sout_q   <= sout_d;
      cflag_q  <= cflag_d;
      zflag_q  <= zflag_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef ALU_VFLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vflag_q <= 1'b0;
    else     vflag_q <= vflag_d;
  end
  assign bus.vflag = vflag_q;
`endif

  assign bus.busy  = (state_q == S_BUSY);
  assign bus.done  = done_q;
  assign bus.sout  = sout_q;
  assign bus.cflag = cflag_q;
  assign bus.zflag = zflag_q;
  assign dbg_state = (state_q == S_BUSY);
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 8-bit registered-flag ALU.
- Adds a WIDTH generic, carry-chained ops (ADC/SBB), compare, and an iterative shift-add multiply.
- Single-cycle ops complete in one clock. MUL runs a WIDTH-cycle state machine.
- Sits between the datapath register file and the controller: the controller issues start, waits for done, then samples sout and the flags.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- ctrl  input  3  opcode, sampled with start.
- ain  input  WIDTH  operand A, sampled with start.
- bin  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while MUL iterates.
- done  output  1  one-cycle completion pulse.
- sout  output  WIDTH  registered result.
- cflag  output  1  registered carry/borrow flag.
- zflag  output  1  registered zero flag.
- vflag  output  1  signed overflow flag; present only with ALU_VFLAG_EN.

Behaviour:
- Reset (async, rst=1): state=IDLE; sout=0, cflag=0, zflag=0, busy=0, done=0, all internal accumulators and counters =0. Reset mid-MUL aborts the operation; no done pulse follows.
- Opcodes (ctrl), all unsigned, computed at WIDTH+1 bits: r={0,ain} op …
  - 000 INC: ain+1
  - 001 DEC: ain−1
  - 010 ADD: ain+bin
  - 011 SUB: ain−bin
  - 100 ADC: ain+bin+cflag
  - 101 SBB: ain−bin−cflag
  - 110 MUL: ain×bin, iterative
  - 111 CMP: ain−bin, flags only
- Carry rule: cflag=r[WIDTH] (carry out for add forms, borrow for subtract forms).
- ADC/SBB use the registered cflag value present on the start cycle.
- Zero rule: zflag=1 iff cflag_next==0 and result_next==0. This is the same convention as the existing ALU.
- CMP: updates cflag/zflag only; sout holds its previous value.
- Single-cycle ops: start in IDLE at edge N → sout/flags updated at edge N+1, done=1 for exactly the cycle after N+1's edge, busy stays 0. Back-to-back starts are accepted every cycle; done then stays high continuously, one pulse per op.
- MUL FSM, states IDLE → BUSY → IDLE:
  - On start: latch multiplicand/multiplier, clear the 2·WIDTH accumulator, cnt=0, busy=1 at the next edge.
  - Each BUSY cycle: if multiplier LSB=1, add multiplicand<<cnt to the accumulator; shift multiplier right; cnt++.
  - After WIDTH iterations: return to IDLE, busy=0; sout=acc[WIDTH−1:0], cflag=|acc[2W−1:W], zflag=(acc==0), done=1 for one cycle.
  - Latency from start edge to done = WIDTH+1 cycles.
- start while busy=1 is ignored (no queuing). ctrl/ain/bin changes during BUSY have no effect.
- Between completions, sout and flags hold. Flags never change except at completion or reset.
- Width edges: DEC of 0 → all-ones result, cflag=1. INC of all-ones → result 0, cflag=1, zflag=0.

Optional Feature:
- Macro: ALU_VFLAG_EN.
- Defined: the vflag port and register exist; reset value 0; updated at every completion.
  - Add forms (INC/ADD/ADC): V=1 when the operand MSBs are equal and the result MSB differs.
  - Subtract forms (DEC/SUB/SBB/CMP): V=1 when the ain and subtrahend MSBs differ and the result MSB differs from ain's MSB.
  - MUL: V=0.
- Undefined: no vflag port and no related logic; all other behaviour is identical.

Test Plan:
- WIDTH=8, reset then ADD ain=0xFF bin=0x01 → next cycle: sout=0x00, cflag=1, zflag=0, done pulse of 1 cycle, busy=0.
- SUB 0x05−0x05 → sout=0x00, cflag=0, zflag=1. Then CMP 0x03 vs 0x05 → sout stays 0x00, cflag=1, zflag=0.
- ADD 0xFF+0x01 (cflag→1), then ADC 0x00+0x00 → sout=0x01, cflag=0, zflag=0. Then SBB 0x00−0x00 with cflag=0 → sout=0x00, zflag=1.
- MUL 0x10×0x10 → busy high 8 cycles, done at cycle 9: sout=0x00, cflag=1, zflag=0. A start pulse (ADD) during busy is ignored, with no extra done. MUL 0x0F×0x11 → sout=0xFF, cflag=0.
- Assert rst at MUL cycle 4 → all outputs 0 immediately; busy=0; no done afterwards. A following INC 0xFF gives sout=0x00, cflag=1.
- ALU_VFLAG_EN defined: ADD 0x7F+0x01 → sout=0x80, vflag=1, cflag=0. SUB 0x80−0x01 → sout=0x7F, vflag=1. Undefined build: compiles with no vflag port.
